// File: rtl/alarm_sched_if.sv
// rtl/alarm_sched_if.sv - control/status bundle between alarm_sched and its neighbours
interface alarm_sched_if;
  logic       i_tick_1hz;
  logic       i_alarm_en;
  logic       i_match;
  logic       i_sw_stop;
  logic       i_sw_snooze;
  logic       o_buzz_en;
  logic [1:0] o_state;
  logic [1:0] o_snooze_cnt;
  logic [8:0] o_remain_sec;

  modport master (
    output i_tick_1hz, i_alarm_en, i_match, i_sw_stop, i_sw_snooze,
    input  o_buzz_en, o_state, o_snooze_cnt, o_remain_sec
  );

  modport slave (
    input  i_tick_1hz, i_alarm_en, i_match, i_sw_stop, i_sw_snooze,
    output o_buzz_en, o_state, o_snooze_cnt, o_remain_sec
  );
endinterface

// File: rtl/alarm_sched.sv
// rtl/alarm_sched.sv - alarm ring/snooze scheduler; ALARM_CHIME_EN selects 1 s on/off chime
module alarm_sched #(
  parameter int RING_SEC   = 60,
  parameter int SNOOZE_SEC = 300,
  parameter int MAX_SNOOZE = 3
) (
  input logic         clk,
  input logic         rst,
  alarm_sched_if.slave bus
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_RING   = 2'd1;
  localparam logic [1:0] ST_SNOOZE = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  localparam logic [8:0] RING_LOAD   = 9'(RING_SEC);
  localparam logic [8:0] SNOOZE_LOAD = 9'(SNOOZE_SEC);
  localparam logic [1:0] SNOOZE_MAX  = 2'(MAX_SNOOZE);

  logic [1:0] state, state_nxt;
  logic [8:0] remain, remain_nxt;
  logic [1:0] cnt, cnt_nxt;
  logic       buzz, buzz_nxt;
  logic       match_q;
  logic       evt;
  logic       last_tick;
`ifdef ALARM_CHIME_EN
  logic       phase, phase_nxt;
`endif

  // Only a fresh rise of the compare starts an alarm; a held match never retriggers.
  assign evt       = bus.i_match & ~match_q;
  assign last_tick = bus.i_tick_1hz && (remain == 9'd1);

  // Next-state decode; buttons are tested before the tick so a coincident tick is dropped.
  always_comb begin
    state_nxt  = state;
    remain_nxt = remain;
    cnt_nxt    = cnt;
`ifdef ALARM_CHIME_EN
    phase_nxt  = phase;
`endif
    case (state)
      ST_IDLE: begin
        if (evt) begin
          state_nxt  = ST_RING;
          remain_nxt = RING_LOAD;
          cnt_nxt    = 2'd0;
`ifdef ALARM_CHIME_EN
          phase_nxt  = 1'b0;
`endif
        end
      end
      ST_RING: begin
        if (bus.i_sw_stop) begin
          state_nxt  = ST_DONE;
          remain_nxt = 9'd0;
        end else if (bus.i_sw_snooze || last_tick) begin
          // Expiry is handled exactly like a snooze press, including the limit.
          if (cnt < SNOOZE_MAX) begin
            state_nxt  = ST_SNOOZE;
            remain_nxt = SNOOZE_LOAD;
            cnt_nxt    = cnt + 2'd1;
          end else begin
            state_nxt  = ST_DONE;
            remain_nxt = 9'd0;
          end
        end else if (bus.i_tick_1hz) begin
          remain_nxt = remain - 9'd1;
`ifdef ALARM_CHIME_EN
          phase_nxt  = ~phase;
`endif
        end
      end
      ST_SNOOZE: begin
        if (bus.i_sw_stop) begin
          state_nxt  = ST_DONE;
          remain_nxt = 9'd0;
        end else if (last_tick) begin
          state_nxt  = ST_RING;
          remain_nxt = RING_LOAD;
`ifdef ALARM_CHIME_EN
          phase_nxt  = 1'b0;
`endif
        end else if (bus.i_tick_1hz) begin
          remain_nxt = remain - 9'd1;
        end
      end
      default: begin
        // DONE waits out the matching minute so the same alarm cannot fire twice.
        remain_nxt = 9'd0;
        if (!bus.i_match) begin
          state_nxt = ST_IDLE;
        end
      end
    endcase

    if (!bus.i_alarm_en) begin
      state_nxt  = ST_IDLE;
      remain_nxt = 9'd0;
      cnt_nxt    = 2'd0;
    end
  end

  // Buzzer follows the next state so it is registered alongside it.
  always_comb begin
`ifdef ALARM_CHIME_EN
    buzz_nxt = (state_nxt == ST_RING) && !phase_nxt;
`else
    buzz_nxt = (state_nxt == ST_RING);
`endif
  end

  // State, counters, match edge register and buzzer update.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      remain  <= 9'd0;
      cnt     <= 2'd0;
      buzz    <= 1'b0;
      match_q <= 1'b0;
`ifdef ALARM_CHIME_EN
      phase   <= 1'b0;
`endif
    end else begin
      state   <= state_nxt;
      remain  <= remain_nxt;
      cnt     <= cnt_nxt;
      buzz    <= buzz_nxt;
      match_q <= bus.i_match;
`ifdef ALARM_CHIME_EN
      phase   <= phase_nxt;
`endif
    end
  end

  assign bus.o_state      = state;
  assign bus.o_remain_sec = remain;
  assign bus.o_snooze_cnt = cnt;
  assign bus.o_buzz_en    = buzz;

endmodule

// File: tb/tb_alarm_sched.sv
// tb/tb_alarm_sched.sv - directed self-checking bench for alarm_sched
`timescale 1ns/1ps
module tb_alarm_sched;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;
  logic [4:0] chime_exp;

  alarm_sched_if bus ();

  alarm_sched #(
    .RING_SEC   (5),
    .SNOOZE_SEC (3),
    .MAX_SNOOZE (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_n(input int n);
    for (int k = 0; k < n; k++) begin
      bus.i_tick_1hz = 1'b1;
      step();
      bus.i_tick_1hz = 1'b0;
    end
  endtask

  task automatic expect_all(input string tag, input int st, input int rem, input int cnt, input int bz);
    check({tag, ".state"},  32'(bus.o_state),      32'(st));
    check({tag, ".remain"}, 32'(bus.o_remain_sec), 32'(rem));
    check({tag, ".cnt"},    32'(bus.o_snooze_cnt), 32'(cnt));
    check({tag, ".buzz"},   32'(bus.o_buzz_en),    32'(bz));
  endtask

  initial begin
`ifdef ALARM_CHIME_EN
    chime_exp = 5'b10101;
`else
    chime_exp = 5'b11111;
`endif
    bus.i_tick_1hz  = 1'b0;
    bus.i_alarm_en  = 1'b1;
    bus.i_match     = 1'b0;
    bus.i_sw_stop   = 1'b0;
    bus.i_sw_snooze = 1'b0;
    step();
    step();
    expect_all("reset", 0, 0, 0, 0);
    rst = 1'b0;
    step();
    expect_all("idle", 0, 0, 0, 0);

    // 1: arm, chime pattern, auto-snooze, return to ring
    bus.i_match = 1'b1;
    step();
    expect_all("s1_ring", 1, 5, 0, 1);
    check("s1_buzz0", 32'(bus.o_buzz_en), 32'(chime_exp[0]));
    for (int k = 1; k <= 4; k++) begin
      tick_n(1);
      check($sformatf("s1_buzz%0d", k), 32'(bus.o_buzz_en), 32'(chime_exp[k]));
      check($sformatf("s1_rem%0d", k), 32'(bus.o_remain_sec), 32'(5 - k));
    end
    tick_n(1);
    expect_all("s1_autosnz", 2, 3, 1, 0);
    tick_n(2);
    check("s1_snz_rem", 32'(bus.o_remain_sec), 32'd1);
    tick_n(1);
    expect_all("s1_rering", 1, 5, 1, 1);

    // 2: snooze limit, match still held so DONE persists
    bus.i_sw_snooze = 1'b1;
    step();
    bus.i_sw_snooze = 1'b0;
    expect_all("s2_snz2", 2, 3, 2, 0);
    bus.i_sw_snooze = 1'b1;
    step();
    bus.i_sw_snooze = 1'b0;
    expect_all("s2_snz_ign", 2, 3, 2, 0);
    tick_n(3);
    expect_all("s2_ring", 1, 5, 2, 1);
    bus.i_sw_snooze = 1'b1;
    step();
    bus.i_sw_snooze = 1'b0;
    expect_all("s2_limit", 3, 0, 2, 0);
    tick_n(1);
    step();
    expect_all("s2_hold", 3, 0, 2, 0);
    bus.i_match = 1'b0;
    step();
    expect_all("s2_idle", 0, 0, 2, 0);

    // 3: stop and snooze together
    bus.i_match = 1'b1;
    step();
    expect_all("s3_ring", 1, 5, 0, 1);
    bus.i_sw_stop   = 1'b1;
    bus.i_sw_snooze = 1'b1;
    step();
    bus.i_sw_stop   = 1'b0;
    bus.i_sw_snooze = 1'b0;
    expect_all("s3_done", 3, 0, 0, 0);
    bus.i_match = 1'b0;
    step();
    check("s3_idle", 32'(bus.o_state), 32'd0);

    // 4: snooze and last tick together, then stop from snooze
    bus.i_match = 1'b1;
    step();
    tick_n(4);
    expect_all("s4_rem1", 1, 1, 0, chime_exp[4]);
    bus.i_sw_snooze = 1'b1;
    bus.i_tick_1hz  = 1'b1;
    step();
    bus.i_sw_snooze = 1'b0;
    bus.i_tick_1hz  = 1'b0;
    expect_all("s4_collide", 2, 3, 1, 0);
    bus.i_sw_stop  = 1'b1;
    bus.i_tick_1hz = 1'b1;
    step();
    bus.i_sw_stop  = 1'b0;
    bus.i_tick_1hz = 1'b0;
    expect_all("s4_stop", 3, 0, 1, 0);
    step();
    check("s4_done_hold", 32'(bus.o_state), 32'd3);
    bus.i_match = 1'b0;
    step();
    check("s4_idle", 32'(bus.o_state), 32'd0);

    // 5: disable in snooze, level match, reset in ring, disabled event
    bus.i_match = 1'b1;
    step();
    bus.i_sw_snooze = 1'b1;
    step();
    bus.i_sw_snooze = 1'b0;
    expect_all("s5_snz", 2, 3, 1, 0);
    bus.i_alarm_en = 1'b0;
    step();
    expect_all("s5_dis", 0, 0, 0, 0);
    bus.i_alarm_en = 1'b1;
    step();
    step();
    check("s5_level", 32'(bus.o_state), 32'd0);
    bus.i_match = 1'b0;
    step();
    bus.i_match = 1'b1;
    step();
    expect_all("s5_ring", 1, 5, 0, 1);
    rst = 1'b1;
    bus.i_match = 1'b0;
    step();
    expect_all("s5_rst", 0, 0, 0, 0);
    rst = 1'b0;
    bus.i_alarm_en = 1'b0;
    bus.i_match    = 1'b1;
    step();
    check("s5_dis_evt", 32'(bus.o_state), 32'd0);
    bus.i_alarm_en = 1'b1;
    step();
    expect_all("s5_no_late", 0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
